// File: rtl/directory_request_scheduler.sv
// directory_request_scheduler: home-node directory controller; round-robin grants one request at a time
// and sequences invalidate, fetch and reply messages before updating the directory entry.
module directory_request_scheduler #(
  parameter int NUM_CPUS = 4,
  parameter int ADDR_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CPUS-1:0]        reqValid,
  input  logic [2*NUM_CPUS-1:0]      reqType,
  input  logic [ADDR_W*NUM_CPUS-1:0] reqBlock,
  output logic [NUM_CPUS-1:0]        reqGrant,
  output logic                       invValid,
  output logic [NUM_CPUS-1:0]        invTargets,
  input  logic                       invAck,
  output logic                       fetchValid,
  output logic [NUM_CPUS-1:0]        fetchTarget,
  output logic                       fetchInvalidate,
  input  logic                       fetchAck,
  output logic                       replyValid,
  output logic [NUM_CPUS-1:0]        replyTarget,
  input  logic                       replyReady,
  output logic                       busy
);
  localparam int PW = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic [2:0] {IDLE, LOOKUP, INVAL, FETCH, REPLY, UPDATE} state_t;
  state_t state, nxt, after_inv;
  logic [1:0] dir_st [DEPTH];
  logic [NUM_CPUS-1:0] dir_sh [DEPTH];
  logic [PW-1:0] ptr, gidx;
  logic found;
  logic [1:0] typ;
  logic [ADDR_W-1:0] blk;
  logic [NUM_CPUS-1:0] req_oh, e_sh;
  logic [NUM_CPUS-1:0] a_inv, a_fetch, a_sh, lk_inv, lk_fetch, lk_sh, c_inv, c_fetch;
  logic a_finv, a_reply, a_wr, lk_reply, lk_wr, c_finv, c_reply;
  logic [1:0] a_st, lk_st, e_st;
  logic is_m, is_s, wb, wr;
  assign busy = state != IDLE;
  assign reqGrant = (rst_n && state == IDLE && found) ? NUM_CPUS'(1) << gidx : '0;
  always_comb begin
    found = 1'b0;
    gidx = '0;
    for (int k = 0; k < NUM_CPUS; k++) begin
      if (!found && reqValid[(int'(ptr) + k) % NUM_CPUS]) begin
        found = 1'b1;
        gidx = PW'((int'(ptr) + k) % NUM_CPUS);
      end
    end
  end
  // Upgrade behaves exactly like writeMiss in every state, so only the write bit matters.
  always_comb begin
    e_st = dir_st[blk];
    e_sh = dir_sh[blk];
    is_m = e_st == 2'b11;
    is_s = e_st == 2'b10;
    wb = typ == 2'b00;
    wr = typ[1];
    lk_reply = !wb;
    lk_inv = (wr && is_s) ? e_sh & ~req_oh : '0;
    lk_fetch = (!wb && is_m && !(wr && e_sh == req_oh)) ? e_sh : '0;
    lk_wr = !wb || (is_m && e_sh == req_oh);
    lk_st = wb ? 2'b01 : wr ? 2'b11 : 2'b10;
    lk_sh = wb ? '0 : wr ? req_oh : (is_s || is_m) ? e_sh | req_oh : req_oh;
    c_inv = (state == LOOKUP) ? lk_inv : a_inv;
    c_fetch = (state == LOOKUP) ? lk_fetch : a_fetch;
    c_finv = (state == LOOKUP) ? wr : a_finv;
    c_reply = (state == LOOKUP) ? lk_reply : a_reply;
    after_inv = (c_fetch != '0) ? FETCH : c_reply ? REPLY : UPDATE;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = found ? LOOKUP : IDLE;
      LOOKUP:  nxt = (c_inv != '0) ? INVAL : after_inv;
      INVAL:   nxt = invAck ? after_inv : INVAL;
      FETCH:   nxt = fetchAck ? (c_reply ? REPLY : UPDATE) : FETCH;
      REPLY:   nxt = replyReady ? UPDATE : REPLY;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  // Message outputs are loaded from the state being entered so they stay flat for the whole phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      typ <= '0;
      blk <= '0;
      req_oh <= '0;
      a_inv <= '0;
      a_fetch <= '0;
      a_finv <= 1'b0;
      a_reply <= 1'b0;
      a_wr <= 1'b0;
      a_st <= 2'b01;
      a_sh <= '0;
      invValid <= 1'b0;
      invTargets <= '0;
      fetchValid <= 1'b0;
      fetchTarget <= '0;
      fetchInvalidate <= 1'b0;
      replyValid <= 1'b0;
      replyTarget <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dir_st[i] <= 2'b01;
        dir_sh[i] <= '0;
      end
    end else begin
      if (state == IDLE && found) begin
        ptr <= (int'(gidx) == NUM_CPUS - 1) ? '0 : gidx + 1'b1;
        typ <= reqType[2*int'(gidx) +: 2];
        blk <= reqBlock[ADDR_W*int'(gidx) +: ADDR_W];
        req_oh <= NUM_CPUS'(1) << gidx;
      end
      if (state == LOOKUP) begin
        a_inv <= lk_inv;
        a_fetch <= lk_fetch;
        a_finv <= wr;
        a_reply <= lk_reply;
        a_wr <= lk_wr;
        a_st <= lk_st;
        a_sh <= lk_sh;
      end
      if (state == UPDATE && a_wr) begin
        dir_st[blk] <= a_st;
        dir_sh[blk] <= a_sh;
      end
      invValid <= nxt == INVAL;
      invTargets <= (nxt == INVAL) ? c_inv : '0;
      fetchValid <= nxt == FETCH;
      fetchTarget <= (nxt == FETCH) ? c_fetch : '0;
      fetchInvalidate <= (nxt == FETCH) && c_finv;
      replyValid <= nxt == REPLY;
      replyTarget <= (nxt == REPLY) ? req_oh : '0;
    end
  end
endmodule

// File: tb/tb_directory_request_scheduler.sv
// tb_directory_request_scheduler: directed and randomized transactions checked against a
// table-driven directory model kept per block as (state, sharer set).
module tb_directory_request_scheduler;
  localparam logic [1:0] WB = 2'd0, RM = 2'd1, WM = 2'd2, UP = 2'd3;
  localparam int MI = 0, MS = 1, MM = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] reqValid = '0;
  logic [7:0] reqType = '0;
  logic [15:0] reqBlock = '0;
  logic [3:0] reqGrant, invTargets, fetchTarget, replyTarget;
  logic invValid, fetchValid, fetchInvalidate, replyValid, busy;
  logic invAck = 1'b0, fetchAck = 1'b0, replyReady = 1'b0;
  int total = 0, bad = 0, cyc = 0;
  int m_st [16];
  logic [3:0] m_sh [16];
  int m_ptr;
  logic [3:0] o_g, o_inv, o_fetch, o_rep;
  logic o_finv;
  int o_lat, o_err;
  bit o_to;
  logic [3:0] e_inv, e_fetch, e_rep;
  logic e_finv;

  directory_request_scheduler #(.NUM_CPUS(4), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqType(reqType), .reqBlock(reqBlock),
    .reqGrant(reqGrant), .invValid(invValid), .invTargets(invTargets), .invAck(invAck),
    .fetchValid(fetchValid), .fetchTarget(fetchTarget), .fetchInvalidate(fetchInvalidate),
    .fetchAck(fetchAck), .replyValid(replyValid), .replyTarget(replyTarget),
    .replyReady(replyReady), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_st[i] = MI;
      m_sh[i] = '0;
    end
    m_ptr = 0;
  endfunction

  // Directory action table: expected messages for one request, then the new entry.
  function automatic void model(input int c, input logic [1:0] t, input int b);
    logic [3:0] r;
    r = 4'(1 << c);
    e_inv = '0;
    e_fetch = '0;
    e_finv = 1'b0;
    e_rep = '0;
    if (t == WB) begin
      if (m_st[b] == MM && m_sh[b] == r) begin
        m_st[b] = MI;
        m_sh[b] = '0;
      end
    end else if (t == RM) begin
      e_rep = r;
      if (m_st[b] == MM) e_fetch = m_sh[b];
      m_sh[b] = (m_st[b] == MI) ? r : (m_sh[b] | r);
      m_st[b] = MS;
    end else begin
      e_rep = r;
      if (m_st[b] == MS) e_inv = m_sh[b] & ~r;
      if (m_st[b] == MM && m_sh[b] != r) begin
        e_fetch = m_sh[b];
        e_finv = 1'b1;
      end
      m_st[b] = MM;
      m_sh[b] = r;
    end
    m_ptr = (c + 1) % 4;
  endfunction

  function automatic logic [16:0] obs();
    return {o_g, o_inv, o_fetch, o_finv, o_rep};
  endfunction

  // One request from one CPU; acks are raised once a phase has been visible for more than dly cycles.
  task automatic run_txn(input int c, input logic [1:0] t, input int b, input int dly);
    int n, ci, cf, cr, t0;
    o_g = '0; o_inv = '0; o_fetch = '0; o_finv = 1'b0; o_rep = '0;
    o_lat = -1; o_err = 0; o_to = 1'b0;
    ci = 0; cf = 0; cr = 0; t0 = 0;
    @(negedge clk);
    reqValid = 4'(1 << c);
    reqType[2*c +: 2] = t;
    reqBlock[4*c +: 4] = 4'(b);
    n = 0;
    while (o_g == 0 && n < 40) begin
      #1;
      if (reqGrant != 0) begin
        o_g = reqGrant;
        t0 = cyc;
      end
      @(negedge clk);
      n++;
    end
    reqValid = '0;
    n = 0;
    while (n < 200 && (n == 0 || busy)) begin
      if (int'(invValid) + int'(fetchValid) + int'(replyValid) > 1) o_err++;
      if (invValid) begin
        if (ci > 0 && invTargets !== o_inv) o_err++;
        o_inv = invTargets;
        ci++;
      end
      if (fetchValid) begin
        if (cf > 0 && (fetchTarget !== o_fetch || fetchInvalidate !== o_finv)) o_err++;
        o_fetch = fetchTarget;
        o_finv = fetchInvalidate;
        cf++;
      end
      if (replyValid) begin
        if (cr > 0 && replyTarget !== o_rep) o_err++;
        if (cr == 0) o_lat = cyc - t0;
        o_rep = replyTarget;
        cr++;
      end
      invAck = invValid && ci > dly;
      fetchAck = fetchValid && cf > dly;
      replyReady = replyValid && cr > dly;
      @(negedge clk);
      n++;
    end
    invAck = 1'b0; fetchAck = 1'b0; replyReady = 1'b0;
    if (o_g == 0 || busy) o_to = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({reqGrant, invValid, invTargets, fetchValid, fetchTarget, fetchInvalidate, replyValid, replyTarget, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0", {reqGrant, invValid, invTargets, fetchValid, fetchTarget, fetchInvalidate, replyValid, replyTarget, busy});
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || reqGrant !== 4'b0) begin
      bad++;
      $display("FAIL reset_release got busy=%b grant=%b exp busy=0 grant=0000", busy, reqGrant);
    end
  endtask

  task automatic test_read_miss();
    run_txn(1, RM, 3, 0);
    model(1, RM, 3);
    total++;
    if (obs() !== {4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0010} || o_err != 0 || o_to) begin
      bad++;
      $display("FAIL rm_cpu1 got=%b err=%0d to=%0d exp=%b", obs(), o_err, o_to, {4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0010});
    end
    total++;
    if (o_lat != 2) begin
      bad++;
      $display("FAIL rm_latency got=%0d exp=2", o_lat);
    end
  endtask

  task automatic test_write_inval();
    for (int i = 0; i < 2; i++) begin
      run_txn(2 * i, RM, 3, 1);
      model(2 * i, RM, 3);
      total++;
      if (obs() !== {4'(1 << (2 * i)), 4'b0000, 4'b0000, 1'b0, 4'(1 << (2 * i))} || o_err != 0 || o_to) begin
        bad++;
        $display("FAIL rm_share%0d got=%b err=%0d to=%0d", i, obs(), o_err, o_to);
      end
    end
    run_txn(3, WM, 3, 2);
    model(3, WM, 3);
    total++;
    if (obs() !== {4'b1000, 4'b0111, 4'b0000, 1'b0, 4'b1000} || o_err != 0 || o_to) begin
      bad++;
      $display("FAIL wm_inval got=%b err=%0d to=%0d exp=%b", obs(), o_err, o_to, {4'b1000, 4'b0111, 4'b0000, 1'b0, 4'b1000});
    end
  endtask

  task automatic test_fetch();
    run_txn(0, RM, 3, 5);
    model(0, RM, 3);
    total++;
    if (obs() !== {4'b0001, 4'b0000, 4'b1000, 1'b0, 4'b0001} || o_err != 0 || o_to) begin
      bad++;
      $display("FAIL rm_fetch got=%b err=%0d to=%0d exp=%b", obs(), o_err, o_to, {4'b0001, 4'b0000, 4'b1000, 1'b0, 4'b0001});
    end
    run_txn(2, UP, 3, 0);
    model(2, UP, 3);
    total++;
    if (obs() !== {4'b0100, 4'b1001, 4'b0000, 1'b0, 4'b0100} || o_err != 0 || o_to) begin
      bad++;
      $display("FAIL up_not_sharer got=%b err=%0d to=%0d exp=%b", obs(), o_err, o_to, {4'b0100, 4'b1001, 4'b0000, 1'b0, 4'b0100});
    end
  endtask

  task automatic test_writeback();
    for (int i = 0; i < 2; i++) begin
      run_txn(2, WB, 3, 0);
      model(2, WB, 3);
      total++;
      if (obs() !== {4'b0100, 13'b0} || o_err != 0 || o_to) begin
        bad++;
        $display("FAIL wb%0d got=%b err=%0d to=%0d exp=%b", i, obs(), o_err, o_to, {4'b0100, 13'b0});
      end
    end
    run_txn(1, RM, 3, 0);
    model(1, RM, 3);
    total++;
    if (obs() !== {4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0010} || o_err != 0 || o_to) begin
      bad++;
      $display("FAIL wb_left_invalid got=%b err=%0d to=%0d", obs(), o_err, o_to);
    end
    run_txn(1, WM, 6, 0);
    model(1, WM, 6);
    run_txn(2, WB, 6, 0);
    model(2, WB, 6);
    run_txn(0, RM, 6, 1);
    model(0, RM, 6);
    total++;
    if (obs() !== {4'b0001, 4'b0000, 4'b0010, 1'b0, 4'b0001} || o_err != 0 || o_to) begin
      bad++;
      $display("FAIL wb_stale_kept got=%b err=%0d to=%0d exp=%b", obs(), o_err, o_to, {4'b0001, 4'b0000, 4'b0010, 1'b0, 4'b0001});
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] pend, exp_g, g;
    int n, idx;
    run_txn(1, RM, 12, 0);
    model(1, RM, 12);
    @(negedge clk);
    pend = 4'hF;
    for (int i = 0; i < 4; i++) begin
      reqType[2*i +: 2] = RM;
      reqBlock[4*i +: 4] = 4'(8 + i);
    end
    reqValid = pend;
    invAck = 1'b1; fetchAck = 1'b1; replyReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_g = '0;
      idx = 0;
      for (int j = 0; j < 4; j++) begin
        if (exp_g == 0 && pend[(m_ptr + j) % 4]) begin
          idx = (m_ptr + j) % 4;
          exp_g = 4'(1 << idx);
        end
      end
      g = '0;
      n = 0;
      while (g == 0 && n < 30) begin
        #1;
        g = reqGrant;
        @(negedge clk);
        n++;
      end
      total++;
      if (g !== exp_g) begin
        bad++;
        $display("FAIL rr_grant%0d got=%b exp=%b", k, g, exp_g);
      end
      pend &= ~exp_g;
      reqValid = pend;
      model(idx, RM, 8 + idx);
    end
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    invAck = 1'b0; fetchAck = 1'b0; replyReady = 1'b0;
    reqValid = '0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rr_drain got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_random();
    int c, b, d;
    logic [1:0] t;
    for (int i = 0; i < 80; i++) begin
      c = $urandom_range(0, 3);
      t = 2'($urandom_range(0, 3));
      b = $urandom_range(0, 3);
      d = $urandom_range(0, 3);
      run_txn(c, t, b, d);
      model(c, t, b);
      total++;
      if (obs() !== {4'(1 << c), e_inv, e_fetch, e_finv, e_rep} || o_err != 0 || o_to) begin
        bad++;
        $display("FAIL rand%0d cpu=%0d type=%0d blk=%0d got=%b err=%0d to=%0d exp=%b", i, c, t, b, obs(), o_err, o_to, {4'(1 << c), e_inv, e_fetch, e_finv, e_rep});
      end
      if (e_inv == 0 && e_fetch == 0 && e_rep != 0) begin
        total++;
        if (o_lat != 2) begin
          bad++;
          $display("FAIL rand%0d_latency got=%0d exp=2", i, o_lat);
        end
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    int n;
    run_txn(3, WM, 7, 0);
    model(3, WM, 7);
    @(negedge clk);
    reqValid = 4'b0001;
    reqType[1:0] = RM;
    reqBlock[3:0] = 4'd7;
    n = 0;
    #1;
    while (reqGrant == 0 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    reqValid = '0;
    n = 0;
    while (!fetchValid && n < 30) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (fetchValid !== 1'b1 || fetchTarget !== 4'b1000) begin
      bad++;
      $display("FAIL mid_fetch_reached got valid=%b target=%b exp valid=1 target=1000", fetchValid, fetchTarget);
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({reqGrant, invValid, invTargets, fetchValid, fetchTarget, fetchInvalidate, replyValid, replyTarget, busy} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs got=%b exp=0", {reqGrant, invValid, invTargets, fetchValid, fetchTarget, fetchInvalidate, replyValid, replyTarget, busy});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_busy got=%b exp=0", busy);
    end
    for (int i = 0; i < 4; i++) begin
      run_txn(i, WM, 7 - 4 * (i % 2), 0);
      model(i, WM, 7 - 4 * (i % 2));
      total++;
      if (obs() !== {4'(1 << i), e_inv, e_fetch, e_finv, e_rep} || o_err != 0 || o_to) begin
        bad++;
        $display("FAIL post_reset%0d got=%b err=%0d to=%0d exp=%b", i, obs(), o_err, o_to, {4'(1 << i), e_inv, e_fetch, e_finv, e_rep});
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_inval();
    test_fetch();
    test_writeback();
    test_round_robin();
    test_random();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/directory_request_scheduler.md
Name: directory_request_scheduler

Overview:
- Home-node controller for the directory coherence protocol. Arbitrates miss, upgrade and writeback requests from NUM_CPUS caches, round-robin.
- Owns the directory entry array (state plus sharer vector per block).
- Sequences per-request invalidate, fetch and data-value-reply messages, then updates the entry. One request in flight at a time.

Parameters:
- NUM_CPUS, 4, number of requesting caches; width of sharer/target vectors.
- ADDR_W, 4, block index width; directory depth = 2**ADDR_W entries.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- reqValid  in  NUM_CPUS  per-CPU request pending; held until granted
- reqType  in  2*NUM_CPUS  per-CPU type, slice i = [2i+1:2i]: 00 writeback, 01 readMiss, 10 writeMiss, 11 upgrade (invalidate on write hit)
- reqBlock  in  ADDR_W*NUM_CPUS  per-CPU block index, slice i
- reqGrant  out  NUM_CPUS  one-hot, one-cycle pulse; request captured on this cycle
- invValid  out  1  invalidate message valid
- invTargets  out  NUM_CPUS  CPUs to invalidate
- invAck  in  1  all invalidates done
- fetchValid  out  1  fetch request to owner
- fetchTarget  out  NUM_CPUS  one-hot owner
- fetchInvalidate  out  1  1 = fetch/invalidate (owner goes INVALID), 0 = fetch (owner goes SHARED)
- fetchAck  in  1  owner data written back
- replyValid  out  1  data value reply valid
- replyTarget  out  NUM_CPUS  one-hot requester
- replyReady  in  1  reply accepted
- busy  out  1  FSM not in IDLE

Behaviour:
- Entry state encoding: 01 INVALID (uncached), 10 SHARED, 11 MODIFIED. 00 is read as INVALID.
- Reset (async, any time, including mid-transaction): every entry = INVALID with sharers 0; FSM = IDLE; RR pointer = 0; all outputs 0. The in-flight request is dropped.
- FSM states: IDLE, LOOKUP, INVAL, FETCH, REPLY, UPDATE.
- IDLE: if any reqValid, grant the first valid CPU at or after the RR pointer (wrap). reqGrant pulses; type, block and requester are registered; pointer becomes granted+1 mod NUM_CPUS. Next state LOOKUP.
- LOOKUP (1 cycle): read the entry and compute the action from the table below. Next state is the first required of INVAL, FETCH, REPLY; otherwise UPDATE.
- INVAL: invValid=1 with invTargets held stable until invAck is sampled 1. Skipped if the target set is 0.
- FETCH: fetchValid, fetchTarget and fetchInvalidate held until fetchAck is sampled 1.
- REPLY: replyValid=1, replyTarget = requester, held until replyReady is sampled 1.
- UPDATE (1 cycle): write the new entry, then go to IDLE. Earliest next grant is the cycle after UPDATE.
- Action table (r = requester one-hot, S = sharers):
  - readMiss, INVALID: reply; new SHARED, S=r.
  - readMiss, SHARED: reply; S=S|r.
  - readMiss, MODIFIED: fetch(inv=0) from owner, reply; new SHARED, S=owner|r.
  - writeMiss, INVALID: reply; new MODIFIED, S=r.
  - writeMiss, SHARED: invalidate S&~r, reply; new MODIFIED, S=r.
  - writeMiss, MODIFIED: fetch(inv=1) from owner, reply; new MODIFIED, S=r. If owner==r, fetch is skipped.
  - upgrade, SHARED with r in S: invalidate S&~r, reply (acknowledge); new MODIFIED, S=r.
  - upgrade in any other state, or r not in S: handled exactly as writeMiss.
  - writeback, MODIFIED with owner==r: no messages; new INVALID, S=0.
  - writeback otherwise: stale; no messages; entry unchanged.
- Owner = S when the state is MODIFIED (one-hot by construction).
- Minimum latency: grant at cycle T, replyValid at T+2 when no invalidate or fetch is needed. An ack present at phase entry completes that phase in 1 cycle.
- Outputs are registered and change only on state transitions. The message valids (invValid, fetchValid, replyValid) are mutually exclusive.
- Requests arriving while busy are not granted and must stay asserted. reqValid deasserted before grant is simply not seen.

Test Plan:
- Reset, then CPU1 readMiss block 3, replyReady tied 1: grant 0010 at T, replyValid at T+2 with target 0010; entry 3 = SHARED, S=0010.
- CPU0 and CPU2 readMiss block 3, then CPU3 writeMiss block 3: invTargets=0111 until invAck, then reply to 1000; entry = MODIFIED, S=1000.
- CPU0 readMiss on block MODIFIED by CPU3: fetchValid, fetchTarget=1000, fetchInvalidate=0, wait for fetchAck delayed 5 cycles, then reply 0001; entry SHARED, S=1001.
- All four CPUs request simultaneously with pointer at 2: grants in order 0100, 1000, 0001, 0010, one per transaction.
- CPU2 writeback on block MODIFIED by CPU2: no messages, entry becomes INVALID, S=0. A repeated writeback is stale: entry unchanged, no messages.
- Assert rst_n=0 during FETCH: all outputs 0 immediately; after release every entry reads INVALID, busy=0.
